// File: rtl/l2_bank_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : l2_bank_init_ctrl
// Description : Sequences one SRAM/SCM bank with active-low csn/wen. After
//               reset, or when init_req_i is raised while the port is open,
//               it writes INIT_VALUE to every word. It then opens the bank to
//               the interconnect as a pass-through with a registered response.
//               Interconnect requests are stalled (gnt_o=0) while init runs.
//
//               Optional feature macro: L2_INIT_VERIFY_EN
//               When it is defined, every word is read back after the write
//               sweep and compared with INIT_VALUE. verify_err_o reports a
//               mismatch and stays set until the next init starts.
//
// Ports       : clk_i, rst_i        clock, asynchronous active-high reset
//               init_req_i         restart init (honoured only when port open)
//               init_busy_o        init sequence running
//               init_done_o        bank initialised, port open
//               req_i/add_i/wen_i/be_i/wdata_i  interconnect request
//               gnt_o              request accepted this cycle
//               r_valid_o/r_rdata_o  response, one cycle after the grant
//               mem_*_o            bank control (csn/wen active-low)
//               mem_rdata_i        bank read data, 1-cycle latency
//               verify_err_o       sticky verify mismatch (L2_INIT_VERIFY_EN)
//
// Revision    : 1.0  initial release
// ============================================================================
module l2_bank_init_ctrl #(
    parameter int                     BANK_WORDS = 2048,
    parameter int                     DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0,
    localparam int                    BE_W       = DATA_WIDTH / 8,
    localparam int                    ADDR_W     = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  init_req_i,
    output logic                  init_busy_o,
    output logic                  init_done_o,

    input  logic                  req_i,
    input  logic [ADDR_W-1:0]     add_i,
    input  logic                  wen_i,
    input  logic [BE_W-1:0]       be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_rdata_o,

    output logic                  mem_csn_o,
    output logic                  mem_wen_o,
    output logic [BE_W-1:0]       mem_be_o,
    output logic [ADDR_W-1:0]     mem_add_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef L2_INIT_VERIFY_EN
    ,
    output logic                  verify_err_o
`endif
);

    // Index of the last word; the sweep counter leaves its state on this
    // value, so it never has to count past BANK_WORDS-1 even when the bank
    // size is not a power of two.
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(BANK_WORDS - 1);

    typedef enum logic [2:0] {
        ST_START    = 3'd0,
        ST_INIT_WR  = 3'd1,
`ifdef L2_INIT_VERIFY_EN
        ST_VFY_RD   = 3'd2,
        ST_VFY_TAIL = 3'd3,
`endif
        ST_PASS     = 3'd4
    } state_e;

    state_e              state_q,   state_d;
    logic [ADDR_W-1:0]   counter_q, counter_d;
    logic                r_valid_q, r_valid_d;

`ifdef L2_INIT_VERIFY_EN
    // vfy_cmp_q marks the cycle in which mem_rdata_i carries a verify read
    // issued the cycle before.
    logic                vfy_cmp_q, vfy_cmp_d;
    logic                verify_err_q, verify_err_d;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_START;
            counter_q    <= '0;
            r_valid_q    <= 1'b0;
`ifdef L2_INIT_VERIFY_EN
            vfy_cmp_q    <= 1'b0;
            verify_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            r_valid_q    <= r_valid_d;
`ifdef L2_INIT_VERIFY_EN
            vfy_cmp_q    <= vfy_cmp_d;
            verify_err_q <= verify_err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. Bank outputs default to idle with zeroed
    // address/data, which is also what is seen while rst_i is high since
    // the state register then sits in ST_START.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        r_valid_d    = 1'b0;
        gnt_o        = 1'b0;
        init_busy_o  = 1'b1;
        init_done_o  = 1'b0;
        mem_csn_o    = 1'b1;
        mem_wen_o    = 1'b1;
        mem_be_o     = '0;
        mem_add_o    = '0;
        mem_wdata_o  = '0;
`ifdef L2_INIT_VERIFY_EN
        vfy_cmp_d    = 1'b0;
        verify_err_d = verify_err_q;
        if (vfy_cmp_q && (mem_rdata_i != INIT_VALUE)) begin
            verify_err_d = 1'b1;
        end
`endif

        case (state_q)
            ST_START: begin
                counter_d = '0;
                state_d   = ST_INIT_WR;
            end

            ST_INIT_WR: begin
                mem_csn_o   = 1'b0;
                mem_wen_o   = 1'b0;
                mem_be_o    = '1;
                mem_add_o   = counter_q;
                mem_wdata_o = INIT_VALUE;
                if (counter_q == c_last_addr) begin
                    counter_d = '0;
`ifdef L2_INIT_VERIFY_EN
                    state_d   = ST_VFY_RD;
`else
                    state_d   = ST_PASS;
`endif
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end

`ifdef L2_INIT_VERIFY_EN
            ST_VFY_RD: begin
                mem_csn_o = 1'b0;
                mem_wen_o = 1'b1;
                mem_add_o = counter_q;
                vfy_cmp_d = 1'b1;
                if (counter_q == c_last_addr) begin
                    counter_d = '0;
                    state_d   = ST_VFY_TAIL;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end

            // Only waits for the read data of the last word to be compared.
            ST_VFY_TAIL: begin
                state_d = ST_PASS;
            end
`endif

            ST_PASS: begin
                init_busy_o = 1'b0;
                init_done_o = 1'b1;
                mem_wen_o   = wen_i;
                mem_be_o    = be_i;
                mem_add_o   = add_i;
                mem_wdata_o = wdata_i;
                if (init_req_i) begin
                    // Re-init takes priority: the request of this cycle is
                    // not granted and the bank stays deselected. A response
                    // owed for last cycle's grant is already in r_valid_q.
                    state_d = ST_START;
`ifdef L2_INIT_VERIFY_EN
                    verify_err_d = 1'b0;
`endif
                end else begin
                    gnt_o     = req_i;
                    mem_csn_o = ~req_i;
                    r_valid_d = req_i;
                end
            end

            default: begin
                state_d = ST_START;
            end
        endcase
    end

    assign r_valid_o = r_valid_q;
    // The bank already registers its read data, so the response data is a
    // direct feed-through; it is meaningless on write responses.
    assign r_rdata_o = mem_rdata_i;

`ifdef L2_INIT_VERIFY_EN
    assign verify_err_o = verify_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_bank_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_bank_init_ctrl
// Description : Self-checking bench for l2_bank_init_ctrl with a 16-word,
//               32-bit bank and INIT_VALUE=DEADBEEF. Contains a behavioural
//               bank (1-cycle read latency, byte-enable writes) and a
//               word-array reference model of the bank contents used to
//               predict pass-through grants and read responses.
//               Verify-mode sequences are compiled with L2_INIT_VERIFY_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_l2_bank_init_ctrl;

    localparam int          N   = 16;
    localparam int          DW  = 32;
    localparam int          BEW = 4;
    localparam int          AW  = 4;
    localparam logic [31:0] IV  = 32'hDEAD_BEEF;

    logic            clk        = 1'b0;
    logic            rst_i      = 1'b1;
    logic            init_req_i = 1'b0;
    logic            req_i      = 1'b0;
    logic            wen_i      = 1'b1;
    logic [AW-1:0]   add_i      = '0;
    logic [BEW-1:0]  be_i       = '0;
    logic [DW-1:0]   wdata_i    = '0;

    logic            init_busy_o, init_done_o, gnt_o, r_valid_o;
    logic [DW-1:0]   r_rdata_o;
    logic            mem_csn_o, mem_wen_o;
    logic [BEW-1:0]  mem_be_o;
    logic [AW-1:0]   mem_add_o;
    logic [DW-1:0]   mem_wdata_o;
    logic [DW-1:0]   mem_rdata_i;
`ifdef L2_INIT_VERIFY_EN
    logic            verify_err_o;
`endif

    l2_bank_init_ctrl #(
        .BANK_WORDS (N),
        .DATA_WIDTH (DW),
        .INIT_VALUE (IV)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .init_req_i  (init_req_i),
        .init_busy_o (init_busy_o),
        .init_done_o (init_done_o),
        .req_i       (req_i),
        .add_i       (add_i),
        .wen_i       (wen_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .r_valid_o   (r_valid_o),
        .r_rdata_o   (r_rdata_o),
        .mem_csn_o   (mem_csn_o),
        .mem_wen_o   (mem_wen_o),
        .mem_be_o    (mem_be_o),
        .mem_add_o   (mem_add_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
`ifdef L2_INIT_VERIFY_EN
        ,
        .verify_err_o(verify_err_o)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural bank ----------------
    logic [DW-1:0] bank [N];
    logic          corrupt9 = 1'b0;

    always @(posedge clk) begin
        if (!mem_csn_o) begin
            if (!mem_wen_o) begin
                for (int b = 0; b < BEW; b++)
                    if (mem_be_o[b]) bank[mem_add_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= (corrupt9 && mem_add_o == 4'd9) ? (bank[mem_add_o] ^ 32'h1)
                                                               : bank[mem_add_o];
            end
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [N];
    logic          exp_rv   = 1'b0;
    logic          exp_read = 1'b0;
    logic [DW-1:0] exp_rd   = '0;

    // Entered with the DUT in ST_START; walks the whole init sequence,
    // counting edges until the port opens.
    task automatic check_init_seq(input bit pulse, input bit req_hi);
        chk("start_csn",  mem_csn_o,   1);
        chk("start_busy", init_busy_o, 1);
        chk("start_done", init_done_o, 0);
        chk("start_gnt",  gnt_o,       0);
        for (int k = 0; k < N; k++) begin
            step();
            init_req_i = pulse && (k == 4);
            #1;
            chk("init_csn",   mem_csn_o,   0);
            chk("init_wen",   mem_wen_o,   0);
            chk("init_be",    mem_be_o,    4'hF);
            chk("init_add",   mem_add_o,   k);
            chk("init_wdata", mem_wdata_o, IV);
            chk("init_gnt",   gnt_o,       0);
            chk("init_done",  init_done_o, 0);
        end
        init_req_i = 1'b0;
`ifdef L2_INIT_VERIFY_EN
        for (int k = 0; k < N; k++) begin
            step(); #1;
            chk("vfy_csn", mem_csn_o, 0);
            chk("vfy_wen", mem_wen_o, 1);
            chk("vfy_add", mem_add_o, k);
            chk("vfy_done", init_done_o, 0);
        end
        step(); #1;
        chk("tail_done", init_done_o, 0);
        chk("tail_csn",  mem_csn_o,   1);
`endif
        step(); #1;
        chk("done_rise", init_done_o, 1);
        chk("done_busy", init_busy_o, 0);
        chk("done_gnt",  gnt_o,       req_hi);
        for (int i = 0; i < N; i++) ref_mem[i] = IV;
        exp_rv   = req_hi;
        exp_read = req_hi && wen_i;
        exp_rd   = ref_mem[add_i];
    endtask

    // One pass-through cycle compared against the reference model.
    task automatic apply_cycle(input logic rq, input logic wn, input logic [AW-1:0] ad,
                               input logic [BEW-1:0] be, input logic [DW-1:0] wd);
        step();
        req_i = rq; wen_i = wn; add_i = ad; be_i = be; wdata_i = wd;
        #1;
        chk("pass_gnt",    gnt_o,     rq);
        chk("pass_csn",    mem_csn_o, !rq);
        chk("pass_rvalid", r_valid_o, exp_rv);
        if (exp_rv && exp_read) chk("pass_rdata", r_rdata_o, exp_rd);
        exp_rv   = rq;
        exp_read = rq && wn;
        if (rq && wn) exp_rd = ref_mem[ad];
        if (rq && !wn)
            for (int b = 0; b < BEW; b++)
                if (be[b]) ref_mem[ad][8*b +: 8] = wd[8*b +: 8];
    endtask

    typedef struct {
        logic        req, wen;
        logic [3:0]  add, be;
        logic [31:0] wd;
        logic        mwen;
        logic [3:0]  mbe, madd;
        logic [31:0] mwd;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 4'h2, 4'hF, 32'h0000_0001, 1'b0, 4'hF, 4'h2, 32'h0000_0001};
        tbl[1] = '{1'b0, 1'b1, 4'h7, 4'h0, 32'hFFFF_FFFF, 1'b1, 4'h0, 4'h7, 32'hFFFF_FFFF};
        tbl[2] = '{1'b1, 1'b1, 4'hF, 4'h5, 32'hA5A5_A5A5, 1'b1, 4'h5, 4'hF, 32'hA5A5_A5A5};
        tbl[3] = '{1'b1, 1'b0, 4'h0, 4'h8, 32'h1234_0000, 1'b0, 4'h8, 4'h0, 32'h1234_0000};
        tbl[4] = '{1'b0, 1'b0, 4'hA, 4'hC, 32'hCAFE_F00D, 1'b0, 4'hC, 4'hA, 32'hCAFE_F00D};
        tbl[5] = '{1'b1, 1'b1, 4'h0, 4'h0, 32'h0000_0000, 1'b1, 4'h0, 4'h0, 32'h0000_0000};

        // ---- 1: reset state and initial sweep with req_i held high ----
        req_i = 1'b1; wen_i = 1'b1; add_i = 4'h0;
        step(); step(); #1;
        chk("rst_busy",  init_busy_o, 1);
        chk("rst_done",  init_done_o, 0);
        chk("rst_gnt",   gnt_o,       0);
        chk("rst_csn",   mem_csn_o,   1);
        chk("rst_wen",   mem_wen_o,   1);
        chk("rst_be",    mem_be_o,    0);
        chk("rst_add",   mem_add_o,   0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_rvld",  r_valid_o,   0);
        step();
        rst_i = 1'b0;
        #1;
        check_init_seq(1'b0, 1'b1);

        // ---- 2: partial write then read-back ----
        step();
        wen_i = 1'b0; add_i = 4'h3; be_i = 4'h3; wdata_i = 32'h1234_5678;
        #1;
        chk("wr_gnt",   gnt_o,       1);
        chk("wr_csn",   mem_csn_o,   0);
        chk("wr_wen",   mem_wen_o,   0);
        chk("wr_be",    mem_be_o,    4'h3);
        chk("wr_add",   mem_add_o,   4'h3);
        chk("wr_wdata", mem_wdata_o, 32'h1234_5678);
        chk("rd0_rvld", r_valid_o,   1);
        chk("rd0_data", r_rdata_o,   IV);
        step();
        wen_i = 1'b1; be_i = 4'h0;
        #1;
        chk("wr_rvld", r_valid_o, 1);
        chk("rd_gnt",  gnt_o,     1);
        step();
        req_i = 1'b0;
        #1;
        chk("rd_rvld", r_valid_o, 1);
        chk("rd_data", r_rdata_o, 32'hDEAD_5678);

        // ---- 3: init_req_i collides with req_i ----
        step();
        req_i = 1'b1; wen_i = 1'b1; add_i = 4'h5;
        #1;
        chk("pre_gnt", gnt_o, 1);
        step();
        init_req_i = 1'b1;
        #1;
        chk("coll_gnt",  gnt_o,     0);
        chk("coll_csn",  mem_csn_o, 1);
        chk("coll_rvld", r_valid_o, 1);
        chk("coll_data", r_rdata_o, IV);
        step();
        init_req_i = 1'b0; req_i = 1'b0;
        #1;
        chk("coll_rvld_after", r_valid_o, 0);
        check_init_seq(1'b0, 1'b0);

        // ---- 4: asynchronous reset in the middle of the sweep ----
        step();
        init_req_i = 1'b1;
        #1;
        step();
        init_req_i = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) step();
        #1;
        chk("mid_add", mem_add_o, 4'h7);
        chk("mid_csn", mem_csn_o, 0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_csn",  mem_csn_o,   1);
        chk("async_add",  mem_add_o,   0);
        chk("async_busy", init_busy_o, 1);
        step(); step();
        rst_i = 1'b0;
        #1;
        check_init_seq(1'b0, 1'b0);

        // ---- 5: init_req_i during the sweep is ignored ----
        step();
        init_req_i = 1'b1;
        #1;
        step();
        init_req_i = 1'b0;
        #1;
        check_init_seq(1'b1, 1'b0);

        // ---- table-driven pass-through vectors ----
        for (int i = 0; i < 6; i++) begin
            apply_cycle(tbl[i].req, tbl[i].wen, tbl[i].add, tbl[i].be, tbl[i].wd);
            chk("tbl_mwen",  mem_wen_o,   tbl[i].mwen);
            chk("tbl_mbe",   mem_be_o,    tbl[i].mbe);
            chk("tbl_madd",  mem_add_o,   tbl[i].madd);
            chk("tbl_mwd",   mem_wdata_o, tbl[i].mwd);
        end

        // ---- randomized traffic against the reference model ----
        for (int i = 0; i < 300; i++) begin
            apply_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, N - 1)), 4'($urandom), 32'($urandom));
        end
        apply_cycle(1'b0, 1'b1, 4'h0, 4'h0, 32'h0);

`ifdef L2_INIT_VERIFY_EN
        // ---- 6: verify detects a corrupted word ----
        corrupt9 = 1'b1;
        step();
        init_req_i = 1'b1;
        #1;
        step();
        init_req_i = 1'b0;
        #1;
        check_init_seq(1'b0, 1'b0);
        chk("vfy_err_set", verify_err_o, 1);
        corrupt9 = 1'b0;
        step();
        init_req_i = 1'b1;
        #1;
        step();
        init_req_i = 1'b0;
        #1;
        chk("vfy_err_clr", verify_err_o, 0);
        check_init_seq(1'b0, 1'b0);
        chk("vfy_err_clean", verify_err_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
